// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Front-end control sequencer for the stopwatch counter datapath. It
// synchronizes and debounces the four push buttons and interprets the
// joystick. It runs the IDLE/RUN/PAUSE/ADJUST state machine and drives the
// counter's control inputs. Everything lives in the single clk domain.
//
// Ports:
//   clk            system clock
//   rst            synchronous, active-high reset
//   btn_pause      raw pause/resume button (asynchronous)
//   btn_adj        raw adjust-mode button (asynchronous)
//   btn_sel        raw field-select button (asynchronous)
//   btn_clr        raw clear button (asynchronous)
//   jstkPosX       joystick X position (10 bit, synchronous)
//   jstkPosY       joystick Y position (10 bit, synchronous)
//   state          0=IDLE, 1=RUN, 2=PAUSE, 3=ADJUST
//   run_en         high only in RUN
//   adj            high only in ADJUST
//   sel            adjust field: 0=left pair, 1=right pair
//   is_fwd_or_bkwd 1=count up, 0=count down
//   cnt_units      0=milliseconds, 1=min/sec, 2=hr/min
//   clr_pulse      one-cycle clear strobe to the counter
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int HOLD_CYCLES     = 25_000_000,
    parameter int JSTK_HI         = 800,
    parameter int JSTK_LO         = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_pause,
    input  logic       btn_adj,
    input  logic       btn_sel,
    input  logic       btn_clr,
    input  logic [9:0] jstkPosX,
    input  logic [9:0] jstkPosY,
    output logic [1:0] state,
    output logic       run_en,
    output logic       adj,
    output logic       sel,
    output logic       is_fwd_or_bkwd,
    output logic [1:0] cnt_units,
    output logic       clr_pulse
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
    localparam logic [9:0]        TH_HI    = 10'(JSTK_HI);
    localparam logic [9:0]        TH_LO    = 10'(JSTK_LO);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSE  = 2'd2,
        ADJUST = 2'd3
    } state_t;

    // Button vector order: 0=pause, 1=adj, 2=sel, 3=clr.
    logic [3:0]      raw_btn;
    logic [3:0]      sync1;
    logic [3:0]      sync2;
    logic [3:0]      db_level;
    logic [3:0]      press;
    logic [DB_W-1:0] db_cnt [4];

    assign raw_btn = {btn_clr, btn_sel, btn_adj, btn_pause};

    // Two-flop synchronizer followed by a per-button debounce counter. The
    // counter only runs while the synchronized level disagrees with the
    // accepted level, so any bounce back to the accepted level restarts it.
    // The press pulse is registered alongside the level update, which is
    // what gives the FSM its one extra cycle of latency after debounce.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            db_level <= '0;
            press    <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw_btn;
            sync2 <= sync1;
            for (int i = 0; i < 4; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    db_level[i] <= sync2[i];
                    db_cnt[i]   <= '0;
                    press[i]    <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    logic press_pause;
    logic press_adj;
    logic press_sel;
    logic press_clr;

    assign press_pause = press[0];
    assign press_adj   = press[1];
    assign press_sel   = press[2];
    assign press_clr   = press[3];

    // Joystick samples are registered once so the FSM and hold logic only
    // ever look at a stable copy.
    logic [9:0] x_reg;
    logic [9:0] y_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg <= 10'd512;
            y_reg <= 10'd512;
        end else begin
            x_reg <= jstkPosX;
            y_reg <= jstkPosY;
        end
    end

    logic x_hi;
    logic x_lo;
    logic y_hi;
    logic y_lo;
    logic y_defl;

    assign x_hi   = (x_reg >= TH_HI);
    assign x_lo   = (x_reg <= TH_LO);
    assign y_hi   = (y_reg >= TH_HI);
    assign y_lo   = (y_reg <= TH_LO);
    assign y_defl = y_hi | y_lo;

    state_t state_q;
    state_t state_d;
    logic   sel_q;
    logic   sel_d;
    logic   dir_q;
    logic   dir_d;
    logic   clr_q;
    logic   clr_d;
    logic   run_q;
    logic   adj_q;

    // State and control-output register. run_en and adj are decoded from the
    // next state so they move on the same edge as the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            dir_q   <= 1'b1;
            clr_q   <= 1'b0;
            run_q   <= 1'b0;
            adj_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            dir_q   <= dir_d;
            clr_q   <= clr_d;
            run_q   <= (state_d == RUN);
            adj_q   <= (state_d == ADJUST);
        end
    end

    // Next-state logic. Presses are mutually prioritised clr > adj > pause >
    // sel, and the joystick X override only acts in cycles with no press at
    // all, so a held stick never masks a button.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        dir_d   = dir_q;
        clr_d   = 1'b0;

        if (press_clr) begin
            state_d = IDLE;
            clr_d   = 1'b1;
            dir_d   = 1'b1;
        end else if (press_adj) begin
            if (state_q == ADJUST) begin
                state_d = PAUSE;
            end else begin
                state_d = ADJUST;
                sel_d   = 1'b0;
            end
        end else if (press_pause) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = state_q;
            endcase
        end else if (press_sel) begin
            if (state_q == ADJUST) begin
                sel_d = ~sel_q;
            end
        end else if (state_q != ADJUST) begin
            if (x_hi) begin
                dir_d   = 1'b0;
                state_d = RUN;
            end else if (x_lo) begin
                dir_d   = 1'b1;
                state_d = RUN;
            end
        end
    end

    logic [HOLD_W-1:0] hold_cnt;
    logic              armed;
    logic              last_hi;
    logic [1:0]        units_q;
    logic              y_flip;

    // A change of deflection side while the counter is already running
    // means the stick swung across without visiting centre.
    assign y_flip = (hold_cnt != '0) && (y_hi != last_hi);

    // Joystick Y hold-to-step. The counter saturates at HOLD_MAX and the
    // armed flag limits each deflection to a single step; only a centred
    // sample re-arms it. ADJUST leaves armed untouched so a stick held
    // through ADJUST cannot sneak in an extra step afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
            armed    <= 1'b1;
            last_hi  <= 1'b0;
            units_q  <= 2'd1;
        end else if (state_q == ADJUST) begin
            hold_cnt <= '0;
        end else if (!y_defl) begin
            hold_cnt <= '0;
            armed    <= 1'b1;
        end else begin
            last_hi <= y_hi;
            if (y_flip) begin
                armed <= 1'b0;
            end
            if (hold_cnt == HOLD_MAX) begin
                if (armed && !y_flip) begin
                    if (y_hi) begin
                        if (units_q != 2'd0) begin
                            units_q <= units_q - 2'd1;
                        end
                    end else begin
                        if (units_q != 2'd2) begin
                            units_q <= units_q + 2'd1;
                        end
                    end
                end
                armed <= 1'b0;
            end else begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end

    assign state          = state_q;
    assign run_en         = run_q;
    assign adj            = adj_q;
    assign sel            = sel_q;
    assign is_fwd_or_bkwd = dir_q;
    assign cnt_units      = units_q;
    assign clr_pulse      = clr_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//
// Self-checking bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4 and
// HOLD_CYCLES=8. Each table row drives an input pattern and queues the
// outputs expected one cycle before, on, and one cycle after the edge where
// the change must land; a negedge monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    logic       clk;
    logic       rst;
    logic       btn_pause;
    logic       btn_adj;
    logic       btn_sel;
    logic       btn_clr;
    logic [9:0] jstkPosX;
    logic [9:0] jstkPosY;
    logic [1:0] state;
    logic       run_en;
    logic       adj;
    logic       sel;
    logic       is_fwd_or_bkwd;
    logic [1:0] cnt_units;
    logic       clr_pulse;

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (8),
        .JSTK_HI        (800),
        .JSTK_LO        (200)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_pause     (btn_pause),
        .btn_adj       (btn_adj),
        .btn_sel       (btn_sel),
        .btn_clr       (btn_clr),
        .jstkPosX      (jstkPosX),
        .jstkPosY      (jstkPosY),
        .state         (state),
        .run_en        (run_en),
        .adj           (adj),
        .sel           (sel),
        .is_fwd_or_bkwd(is_fwd_or_bkwd),
        .cnt_units     (cnt_units),
        .clr_pulse     (clr_pulse)
    );

    typedef struct {
        string      name;
        int         due;
        logic [8:0] vec;
    } exp_t;

    typedef struct {
        string      name;
        logic [3:0] btn;
        int         x;
        int         y;
        int         len;
        int         chk;
        logic [8:0] vec;
    } vec_t;

    exp_t       sb_q[$];
    vec_t       vecs[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [8:0] last_vec;
    logic [8:0] reset_vec;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output vector layout: {state, run_en, adj, sel, fwd, units, clr}.
    function automatic logic [8:0] pk(logic [1:0] st, logic se, logic di, logic [1:0] un, logic cl);
        return {st, (st == 2'd1), (st == 2'd3), se, di, un, cl};
    endfunction

    function automatic vec_t mkv(string n, logic [3:0] b, int x, int y, int len, int chk,
                                 logic [1:0] st, logic se, logic di, logic [1:0] un, logic cl);
        vec_t v;
        v.name = n;
        v.btn  = b;
        v.x    = x;
        v.y    = y;
        v.len  = len;
        v.chk  = chk;
        v.vec  = pk(st, se, di, un, cl);
        return v;
    endfunction

    task automatic pushExp(input string n, input int due, input logic [8:0] vec);
        exp_t e;
        e.name = n;
        e.due  = due;
        e.vec  = vec;
        sb_q.push_back(e);
    endtask

    // Button order in the vector: 0=pause, 1=adj, 2=sel, 3=clr.
    task automatic driveInputs(input logic [3:0] b, input int x, input int y);
        btn_pause = b[0];
        btn_adj   = b[1];
        btn_sel   = b[2];
        btn_clr   = b[3];
        jstkPosX  = 10'(x);
        jstkPosY  = 10'(y);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [8:0] act;
        act = {state, run_en, adj, sel, is_fwd_or_bkwd, cnt_units, clr_pulse};
        n_checks++;
        if (act !== e.vec) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got st=%0d run=%b adj=%b sel=%b fwd=%b units=%0d clr=%b, expected st=%0d run=%b adj=%b sel=%b fwd=%b units=%0d clr=%b",
                     e.name, cyc, act[8:7], act[6], act[5], act[4], act[3], act[2:1], act[0],
                     e.vec[8:7], e.vec[6], e.vec[5], e.vec[4], e.vec[3], e.vec[2:1], e.vec[0]);
        end
    endtask

    // Drives one table row starting right after a posedge (so the first
    // sampling edge is cyc+1), queues the before/on/after expectations, holds
    // the inputs for len cycles, then idles long enough for buttons to
    // debounce back to released.
    task automatic applyStimulus(input vec_t v);
        int c;
        int total;
        c = cyc;
        driveInputs(v.btn, v.x, v.y);
        pushExp({v.name, " pre"}, c + v.chk - 1, last_vec);
        pushExp(v.name, c + v.chk, v.vec);
        pushExp({v.name, " post"}, c + v.chk + 1, v.vec & ~9'd1);
        last_vec = v.vec & ~9'd1;
        repeat (v.len) @(negedge clk);
        driveInputs(4'b0000, 512, 512);
        total = (v.chk + 2 > v.len + 14) ? v.chk + 2 : v.len + 14;
        while (cyc < c + total) @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            checkOutput(e);
        end
    end

    initial begin : main
        int c;
        reset_vec = pk(2'd0, 1'b0, 1'b1, 2'd1, 1'b0);

        // Buttons: pause=0001 adj=0010 sel=0100 clr=1000. Button rows land
        // 8 cycles after drive, X rows 2 cycles, Y rows 10 cycles.
        vecs.push_back(mkv("pause IDLE->RUN",        4'b0001, 512, 512, 10,  8, 2'd1, 0, 1, 2'd1, 0));
        vecs.push_back(mkv("pause RUN->PAUSE",       4'b0001, 512, 512,  6,  8, 2'd2, 0, 1, 2'd1, 0));
        vecs.push_back(mkv("pause PAUSE->RUN",       4'b0001, 512, 512,  6,  8, 2'd1, 0, 1, 2'd1, 0));
        vecs.push_back(mkv("adj RUN->ADJUST",        4'b0010, 512, 512,  6,  8, 2'd3, 0, 1, 2'd1, 0));
        vecs.push_back(mkv("pause ignored in ADJUST",4'b0001, 512, 512,  6,  8, 2'd3, 0, 1, 2'd1, 0));
        vecs.push_back(mkv("X ignored in ADJUST",    4'b0000, 850, 512,  1,  2, 2'd3, 0, 1, 2'd1, 0));
        vecs.push_back(mkv("Y ignored in ADJUST",    4'b0000, 512, 100, 12, 10, 2'd3, 0, 1, 2'd1, 0));
        vecs.push_back(mkv("sel 0->1 in ADJUST",     4'b0100, 512, 512,  6,  8, 2'd3, 1, 1, 2'd1, 0));
        vecs.push_back(mkv("sel 1->0 in ADJUST",     4'b0100, 512, 512,  6,  8, 2'd3, 0, 1, 2'd1, 0));
        vecs.push_back(mkv("adj ADJUST->PAUSE",      4'b0010, 512, 512,  6,  8, 2'd2, 0, 1, 2'd1, 0));
        vecs.push_back(mkv("sel ignored in PAUSE",   4'b0100, 512, 512,  6,  8, 2'd2, 0, 1, 2'd1, 0));
        vecs.push_back(mkv("clr PAUSE->IDLE",        4'b1000, 512, 512,  6,  8, 2'd0, 0, 1, 2'd1, 1));
        vecs.push_back(mkv("X=800 from IDLE",        4'b0000, 800, 512,  1,  2, 2'd1, 0, 0, 2'd1, 0));
        vecs.push_back(mkv("X=200 forward",          4'b0000, 200, 512,  1,  2, 2'd1, 0, 1, 2'd1, 0));
        vecs.push_back(mkv("Y=100 x30 step up",      4'b0000, 512, 100, 30, 10, 2'd1, 0, 1, 2'd2, 0));
        vecs.push_back(mkv("Y=200 x30 saturate 2",   4'b0000, 512, 200, 30, 10, 2'd1, 0, 1, 2'd2, 0));
        vecs.push_back(mkv("Y=900 x8 no step",       4'b0000, 512, 900,  8, 10, 2'd1, 0, 1, 2'd2, 0));
        vecs.push_back(mkv("Y=900 x9 step down",     4'b0000, 512, 900,  9, 10, 2'd1, 0, 1, 2'd1, 0));
        vecs.push_back(mkv("X=850 backward",         4'b0000, 850, 512,  1,  2, 2'd1, 0, 0, 2'd1, 0));
        vecs.push_back(mkv("clr+adj same cycle",     4'b1010, 512, 512,  6,  8, 2'd0, 0, 1, 2'd1, 1));
        vecs.push_back(mkv("Y=800 x9 step to 0",     4'b0000, 512, 800,  9, 10, 2'd0, 0, 1, 2'd0, 0));
        vecs.push_back(mkv("Y=800 x9 saturate 0",    4'b0000, 512, 800,  9, 10, 2'd0, 0, 1, 2'd0, 0));
        vecs.push_back(mkv("clr keeps units",        4'b1000, 512, 512,  6,  8, 2'd0, 0, 1, 2'd0, 1));
        vecs.push_back(mkv("X=850 before reset",     4'b0000, 850, 512,  1,  2, 2'd1, 0, 0, 2'd0, 0));

        driveInputs(4'b0000, 512, 512);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        pushExp("reset values", cyc + 1, reset_vec);
        @(negedge clk);
        rst = 1'b0;
        last_vec = reset_vec;

        // Glitches of 1, 2 and 3 cycles must never become a press.
        $display("[TB] pause glitch rejection");
        c = cyc;
        for (int i = 1; i <= 30; i++) pushExp("glitch no press", c + i, reset_vec);
        for (int g = 1; g <= 3; g++) begin
            btn_pause = 1'b1;
            repeat (g) @(negedge clk);
            btn_pause = 1'b0;
            repeat (3) @(negedge clk);
        end
        while (cyc < c + 31) @(negedge clk);

        $display("[TB] table of %0d vectors", vecs.size());
        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Reset in the middle of a pause debounce wipes everything, and the
        // half-counted press must not reappear afterwards.
        $display("[TB] reset mid-debounce");
        btn_pause = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        pushExp("rst mid-debounce", cyc + 1, reset_vec);
        @(negedge clk);
        rst = 1'b0;
        btn_pause = 1'b0;
        c = cyc;
        for (int i = 1; i <= 15; i++) pushExp("no press after rst", c + i, reset_vec);
        while (cyc < c + 16) @(negedge clk);
        last_vec = reset_vec;
        applyStimulus(mkv("pause after reset", 4'b0001, 512, 512, 6, 8, 2'd1, 0, 1, 2'd1, 0));

        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
